// File: rtl/axi_sink_wresp_engine.sv
// AXI-sink W/B engine: pops one {id,len} descriptor per burst, sinks len+1 W beats, answers with one B.
// Optional macro BRESP_DELAY_EN inserts a resp_delay-cycle DELAY state between the last W beat and B.
module axi_sink_wresp_engine #(
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ID_WIDTH+LEN_WIDTH-1:0] desc_in,
    input  logic                          desc_empty,
    output logic                          desc_consumed,
    input  logic [DATA_WIDTH-1:0]         s_wdata,
    input  logic [DATA_WIDTH/8-1:0]       s_wstrb,
    input  logic                          s_wlast,
    input  logic                          s_wvalid,
    output logic                          s_wready,
    output logic [ID_WIDTH-1:0]           s_bid,
    output logic [1:0]                    s_bresp,
    output logic                          s_bvalid,
    input  logic                          s_bready,
    output logic [CNT_WIDTH-1:0]          beat_count,
    output logic [CNT_WIDTH-1:0]          err_count,
    input  logic [7:0]                    resp_delay
);

`ifdef BRESP_DELAY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DELAY, ST_RESP} state_t;
    logic [7:0]            r_dly;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_t;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat_idx;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_beat_count;
    logic [CNT_WIDTH-1:0]  r_err_count;
    logic                  w_accept;
    logic                  w_final;
    logic                  w_burst_end;
    logic                  w_unused;

    // W data/strobes are intentionally dropped
`ifdef BRESP_DELAY_EN
    assign w_unused = ^{s_wdata, s_wstrb};
`else
    assign w_unused = ^{s_wdata, s_wstrb, resp_delay};
`endif

    assign w_accept    = (r_state == ST_DATA) && s_wvalid;
    assign w_final     = (r_beat_idx == r_len);
    // an early WLAST ends the burst just like the final beat does
    assign w_burst_end = w_accept && (w_final || s_wlast);

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        s_wready      = 1'b0;
        s_bvalid      = 1'b0;
        s_bid         = '0;
        s_bresp       = 2'b00;
        desc_consumed = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!desc_empty) w_next = ST_DATA;
            end
            ST_DATA: begin
                s_wready = 1'b1;
                if (w_burst_end) begin
`ifdef BRESP_DELAY_EN
                    w_next = (resp_delay == 8'd0) ? ST_RESP : ST_DELAY;
`else
                    w_next = ST_RESP;
`endif
                end
            end
`ifdef BRESP_DELAY_EN
            ST_DELAY: begin
                if (r_dly <= 8'd1) w_next = ST_RESP;
            end
`endif
            ST_RESP: begin
                s_bvalid      = 1'b1;
                s_bid         = r_id;
                s_bresp       = r_err ? 2'b10 : 2'b00;
                desc_consumed = s_bready && !reset;
                if (s_bready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_id         <= '0;
            r_len        <= '0;
            r_beat_idx   <= '0;
            r_err        <= 1'b0;
            r_beat_count <= '0;
            r_err_count  <= '0;
`ifdef BRESP_DELAY_EN
            r_dly        <= '0;
`endif
        end else begin
            if (r_state == ST_IDLE && !desc_empty) begin
                r_id       <= desc_in[ID_WIDTH+LEN_WIDTH-1:LEN_WIDTH];
                r_len      <= desc_in[LEN_WIDTH-1:0];
                r_beat_idx <= '0;
                r_err      <= 1'b0;
            end
            if (w_accept) begin
                r_beat_idx   <= r_beat_idx + 1'b1;
                r_beat_count <= r_beat_count + 1'b1;
                if (w_final ? !s_wlast : s_wlast) r_err <= 1'b1;
            end
`ifdef BRESP_DELAY_EN
            if (w_burst_end)          r_dly <= resp_delay;
            else if (r_state == ST_DELAY) r_dly <= r_dly - 1'b1;
`endif
            if (r_state == ST_RESP && s_bready && r_err)
                r_err_count <= r_err_count + 1'b1;
        end
    end

    assign beat_count = r_beat_count;
    assign err_count  = r_err_count;

endmodule
